// File: rtl/sort_host.sv
// sort_host: host-side sequencer for the 8-entry selection-sort engine (stream in, write, start, read back, stream out).
// Define SORT_HOST_CHECK_EN to add a sticky monitor that flags a non-ascending output stream on `unsorted`.
module sort_host #(
    parameter int DATA_W  = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              srt_start,
    output logic              srt_wr,
    output logic [AW-1:0]     srt_addr,
    output logic [DATA_W-1:0] srt_datain,
    input  logic [DATA_W-1:0] srt_dataout,
    input  logic              srt_ready,
    output logic              done,
    output logic              err,
    output logic              unsorted
);

    localparam int            TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST     = {AW{1'b1}};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_LOAD, S_WR, S_START, S_WAIT_LO, S_WAIT_HI, S_RD, S_CAP, S_OUT, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_out_data;
    logic              r_done;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_tmo_hit;

    assign w_in_hs   = in_valid && (r_state == S_LOAD);
    assign w_out_hs  = out_ready && (r_state == S_OUT);
    // The final wait cycle is the TIMEOUT-th one spent across WAIT_LO and WAIT_HI.
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_done     <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_out_hs && (r_cnt == LAST);
            if ((r_state == S_WR) || w_out_hs)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            if (r_state == S_START)
                r_tmo <= '0;
            else if ((r_state == S_WAIT_LO) || (r_state == S_WAIT_HI))
                r_tmo <= r_tmo + 1'b1;
            if (r_state == S_CAP)
                r_out_data <= srt_dataout;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs)
            r_wdata <= in_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    if (w_in_hs) w_next = S_WR;
            S_WR:      w_next = (r_cnt == LAST) ? S_START : S_LOAD;
            S_START:   w_next = S_WAIT_LO;
            S_WAIT_LO: if (!srt_ready) w_next = S_WAIT_HI;
                       else if (w_tmo_hit) w_next = S_ERR;
            S_WAIT_HI: if (srt_ready) w_next = S_RD;
                       else if (w_tmo_hit) w_next = S_ERR;
            S_RD:      w_next = S_CAP;
            S_CAP:     w_next = S_OUT;
            S_OUT:     if (w_out_hs) w_next = (r_cnt == LAST) ? S_LOAD : S_RD;
            S_ERR:     w_next = S_ERR;
            default:   w_next = S_ERR;
        endcase
    end

    // cnt stays put through RD/CAP/OUT, so the read address is held for the whole word.
    always_comb begin
        in_ready   = (r_state == S_LOAD);
        out_valid  = (r_state == S_OUT);
        srt_wr     = (r_state == S_WR);
        srt_start  = (r_state == S_START);
        srt_addr   = (r_state == S_ERR) ? '0 : r_cnt;
        srt_datain = (r_state == S_WR) ? r_wdata : '0;
        err        = (r_state == S_ERR);
    end

    assign out_data = r_out_data;
    assign done     = r_done;

`ifdef SORT_HOST_CHECK_EN
    logic [DATA_W-1:0] r_prev;
    logic              r_unsorted;

    always_ff @(posedge clk) begin
        if (rst)
            r_unsorted <= 1'b0;
        else if (w_out_hs && (r_cnt != '0) && (r_out_data < r_prev))
            r_unsorted <= 1'b1;
        else if (w_in_hs && (r_cnt == '0))
            r_unsorted <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_out_hs)
            r_prev <= r_out_data;
    end

    assign unsorted = r_unsorted;
`else
    assign unsorted = 1'b0;
`endif

endmodule

// File: tb/tb_sort_host.sv
// Bench for sort_host: behavioural sort engine, queue-based scoreboard and directed batches.
module tb_sort_host;

`ifdef SORT_HOST_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       srt_start;
    logic       srt_wr;
    logic [2:0] srt_addr;
    logic [7:0] srt_datain;
    logic [7:0] srt_dataout;
    logic       srt_ready;
    logic       done;
    logic       err;
    logic       unsorted;

    sort_host dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .srt_start(srt_start), .srt_wr(srt_wr), .srt_addr(srt_addr),
        .srt_datain(srt_datain), .srt_dataout(srt_dataout), .srt_ready(srt_ready),
        .done(done), .err(err), .unsorted(unsorted)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] sort8(input logic [63:0] v);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    // Engine model: mode 0 sorts, mode 1 never drops ready, mode 2 reads back a fixed stub.
    int          eng_mode = 0;
    logic [63:0] emem;
    logic [63:0] stub_mem;
    logic [7:0]  e_dout;
    logic        e_ready;
    int          e_busy;
    assign srt_dataout = e_dout;
    assign srt_ready   = e_ready;

    initial begin
        emem     = '0;
        stub_mem = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd2, 8'd4};
        e_dout   = '0;
        e_ready  = 1'b1;
        e_busy   = 0;
        forever begin
            @(posedge clk);
            if (srt_wr) emem[{srt_addr, 3'b000} +: 8] <= srt_datain;
            else e_dout <= (eng_mode == 2) ? stub_mem[{srt_addr, 3'b000} +: 8]
                                           : emem[{srt_addr, 3'b000} +: 8];
            if (srt_start && eng_mode != 1) begin
                e_ready <= 1'b0;
                e_busy  <= 10;
            end else if (e_busy > 1) begin
                e_busy <= e_busy - 1;
            end else if (e_busy == 1) begin
                e_busy  <= 0;
                e_ready <= 1'b1;
                emem    <= sort8(emem);
            end
        end
    end

    // Scoreboard state and logs
    logic [7:0]  inq[$];
    logic [7:0]  expq[$];
    logic [7:0]  out_log[$];
    logic [2:0]  out_addr_log[$];
    logic [2:0]  wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    int          start_cnt, wr_at_start, done_cnt, out_idx;
    logic [7:0]  done_with, last_out, prev, e_pop;
    logic        done_exp = 1'b0;
    logic        uns_exp = 1'b0;
    logic [63:0] m_pack, m_sorted;

    initial begin
        out_idx = 0; start_cnt = 0; wr_at_start = -1; done_cnt = 0;
        prev = '0; last_out = '0; done_with = '0;
        forever begin
            @(negedge clk);
            chk("done", 32'(done), 32'(done_exp));
            chk("wr_start_overlap", 32'(srt_wr & srt_start), 0);
            chk("inrdy_outvld_overlap", 32'(in_ready & out_valid), 0);
            chk("unsorted", 32'(unsorted), CHK_EN ? 32'(uns_exp) : 0);
            done_exp = 1'b0;
            if (rst) begin
                inq.delete();
                expq.delete();
                out_idx = 0;
                uns_exp = 1'b0;
            end else begin
                if (srt_wr) begin
                    wr_addr_log.push_back(srt_addr);
                    wr_data_log.push_back(srt_datain);
                end
                if (srt_start) begin
                    start_cnt++;
                    wr_at_start = wr_addr_log.size();
                end
                if (done) begin
                    done_cnt++;
                    done_with = last_out;
                end
                if (in_valid && in_ready) begin
                    if (inq.size() == 0) uns_exp = 1'b0;
                    inq.push_back(in_data);
                    if (inq.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_pack[i*8 +: 8] = inq[i];
                        m_sorted = (eng_mode == 2) ? stub_mem : sort8(m_pack);
                        for (int i = 0; i < 8; i++) expq.push_back(m_sorted[i*8 +: 8]);
                        inq.delete();
                    end
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL out_extra: got word %0d, expected none", out_data);
                    end else begin
                        e_pop = expq.pop_front();
                        chk("out_data", 32'(out_data), 32'(e_pop));
                    end
                    if (out_idx != 0 && out_data < prev) uns_exp = 1'b1;
                    prev     = out_data;
                    last_out = out_data;
                    out_log.push_back(out_data);
                    out_addr_log.push_back(srt_addr);
                    out_idx++;
                    if (out_idx == 8) begin
                        out_idx  = 0;
                        done_exp = 1'b1;
                    end
                end
            end
        end
    end

    logic [7:0] batch[8];
    logic [7:0] exp_words[8];
    int         k;

    task automatic clear_logs();
        out_log.delete();
        out_addr_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        start_cnt   = 0;
        wr_at_start = -1;
        done_cnt    = 0;
    endtask

    task automatic send_batch();
        logic hs;
        int   n;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = batch[i];
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 100) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                n++;
            end
            chk("in_handshake", 32'(hs), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_count"}, 32'(out_log.size()), 8);
        for (int i = 0; i < 8; i++)
            chk({tag, "_word"}, (i < out_log.size()) ? 32'(out_log[i]) : 32'hdead, 32'(exp_words[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_srt_wr", 32'(srt_wr), 0);
        chk("rst_srt_start", 32'(srt_start), 0);
        chk("rst_srt_addr", 32'(srt_addr), 0);
        chk("rst_srt_datain", 32'(srt_datain), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_unsorted", 32'(unsorted), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Batch A: basic sort and pin sequence
        clear_logs();
        batch     = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        exp_words = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        send_batch();
        wait_done(300);
        check_out("a_out");
        chk("a_wr_count", 32'(wr_addr_log.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk("a_wr_addr", (i < wr_addr_log.size()) ? 32'(wr_addr_log[i]) : 32'hdead, 32'(i));
            chk("a_wr_data", (i < wr_data_log.size()) ? 32'(wr_data_log[i]) : 32'hdead, 32'(batch[i]));
            chk("a_rd_addr", (i < out_addr_log.size()) ? 32'(out_addr_log[i]) : 32'hdead, 32'(i));
        end
        chk("a_start_count", 32'(start_cnt), 1);
        chk("a_writes_before_start", 32'(wr_at_start), 8);
        chk("a_done_count", 32'(done_cnt), 1);
        chk("a_done_word", 32'(done_with), 7);
        chk("a_err", 32'(err), 0);
        chk("a_unsorted", 32'(unsorted), 0);
        chk("a_scoreboard_empty", 32'(expq.size()), 0);

        // Batch B: five-cycle downstream stall on word 2
        clear_logs();
        batch = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        send_batch();
        k = 0;
        @(negedge clk);
        while (!(out_valid && out_data == 8'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("b_word1_seen", 32'(out_valid && out_data == 8'd1), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("b_stall_data", 32'(out_data), 2);
            chk("b_stall_valid", 32'(out_valid), 1);
            chk("b_stall_addr", 32'(srt_addr), 2);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(300);
        check_out("b_out");
        chk("b_done_count", 32'(done_cnt), 1);

        // Batch C: extreme values and duplicates
        clear_logs();
        batch     = '{8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd1, 8'd254, 8'd127};
        exp_words = '{8'd0, 8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255, 8'd255};
        send_batch();
        wait_done(300);
        check_out("c_out");

        // Reset while holding the fourth word in OUT
        clear_logs();
        batch = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        send_batch();
        k = 0;
        while (out_log.size() < 3 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1 out_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("r_held_word", 32'(out_data), 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("r_out_valid", 32'(out_valid), 0);
        chk("r_in_ready", 32'(in_ready), 1);
        chk("r_cnt_addr", 32'(srt_addr), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        clear_logs();
        batch     = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        exp_words = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        send_batch();
        wait_done(300);
        check_out("r_nines");

        // Stub engine returning a descending pair first
        clear_logs();
        eng_mode  = 2;
        batch     = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_words = '{8'd4, 8'd2, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        send_batch();
        k = 0;
        while (out_log.size() < 2 && k < 300) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk("f_unsorted_set", 32'(unsorted), CHK_EN ? 1 : 0);
        wait_done(300);
        check_out("f_stub");
        chk("f_unsorted_sticky", 32'(unsorted), CHK_EN ? 1 : 0);
        eng_mode = 0;
        clear_logs();
        batch     = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        exp_words = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        send_batch();
        chk("f_unsorted_cleared", 32'(unsorted), 0);
        wait_done(300);
        check_out("f_after");

        // Engine that never drops ready: timeout into ERR
        clear_logs();
        eng_mode = 1;
        batch    = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        send_batch();
        k = 0;
        @(negedge clk);
        while (!srt_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t_start_seen", 32'(srt_start), 1);
        repeat (1023) @(negedge clk);
        chk("t_err_before", 32'(err), 0);
        @(negedge clk);
        chk("t_err", 32'(err), 1);
        chk("t_in_ready", 32'(in_ready), 0);
        chk("t_out_valid", 32'(out_valid), 0);
        chk("t_srt_wr", 32'(srt_wr), 0);
        chk("t_srt_start", 32'(srt_start), 0);
        chk("t_srt_addr", 32'(srt_addr), 0);
        repeat (3) @(negedge clk);
        chk("t_err_sticky", 32'(err), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        eng_mode = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t_err_cleared", 32'(err), 0);
        chk("t_in_ready_back", 32'(in_ready), 1);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sort_host.md
Name: sort_host

Overview:
Host-side initiator for the 8-entry selection-sort engine. It drives the engine's load, start and read-back interface, so the engine's wr/addr/datain/start/ready/dataout pins are always driven by this block.
Upstream side: a valid/ready stream of DEPTH unsorted bytes. Downstream side: a valid/ready stream of the DEPTH sorted bytes.
Sequencing: stream in, write all words to the engine, pulse start, wait for the engine to finish, read back every address, stream out, repeat.

Parameters:
DATA_W, 8, word width; must match engine data width
AW, 3, engine address width; DEPTH = 1<<AW words per batch
TIMEOUT, 1023, max cycles spent in WAIT_LO plus WAIT_HI before error

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream word valid
in_data  in  DATA_W  upstream word
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  sorted word valid
out_data  out  DATA_W  sorted word, ascending order
out_ready  in  1  downstream accepts out_data
srt_start  out  1  to engine start
srt_wr  out  1  to engine wr
srt_addr  out  AW  to engine addr
srt_datain  out  DATA_W  to engine datain
srt_dataout  in  DATA_W  from engine dataout; valid 1 cycle after srt_addr is presented with srt_wr=0
srt_ready  in  1  from engine ready
done  out  1  1-cycle pulse when the last sorted word handshakes
err  out  1  sticky timeout flag
unsorted  out  1  see Optional Feature

Behaviour:
- Output style: all outputs are Moore, decoded from registered state, cnt and data registers. There is no combinational path from in_* or srt_* to srt_*.
- Reset: state=LOAD, cnt=0, tmo=0, and every output register is 0: srt_*, out_data, out_valid, done, err, unsorted. in_ready=1 after reset because state is LOAD.
- Reset mid-operation: abandons the batch; the partial batch is discarded. The engine is not reset by this block.
- LOAD: in_ready=1. On in_valid&in_ready: capture in_data into wdata and go to WR.
- WR: srt_wr=1, srt_addr=cnt, srt_datain=wdata for exactly 1 cycle; in_ready=0.
  - If cnt==DEPTH-1: cnt<=0, go to START.
  - Otherwise: cnt<=cnt+1, go to LOAD.
  - Throughput is 2 cycles per input word.
- START: srt_start=1 for exactly 1 cycle with srt_wr=0, then go to WAIT_LO.
- WAIT_LO: wait for srt_ready==0, which confirms the engine accepted start, then go to WAIT_HI.
- WAIT_HI: wait for srt_ready==1, then go to RD.
- Timeout: tmo increments every cycle in WAIT_LO and WAIT_HI. When tmo reaches TIMEOUT, go to ERR. tmo clears on entering START.
- RD: srt_wr=0, srt_addr=cnt, engine read enabled, for 1 cycle; go to CAP.
- CAP: out_data<=srt_dataout, out_valid<=1; go to OUT.
- OUT: hold out_data and out_valid until out_ready. On out_valid&out_ready:
  - out_valid<=0.
  - If cnt==DEPTH-1: cnt<=0, done pulse, go to LOAD.
  - Otherwise: cnt<=cnt+1, go to RD.
  - The srt_addr value is held stable through RD, CAP and OUT.
- ERR: err=1, in_ready=0, out_valid=0, all srt_* = 0. Only rst exits ERR.
- Simultaneous events:
  - srt_start and srt_wr are never both 1.
  - in_ready and out_valid are never both 1.
  - in_ready=0 in every state except LOAD.
- Counter: cnt is AW bits; wrap is explicit at DEPTH-1, never by overflow-and-continue.

Optional Feature:
SORT_HOST_CHECK_EN
- Defined: keep prev (DATA_W) = last emitted word.
  - On each out handshake with cnt!=0 and out_data<prev (unsigned), set unsorted<=1.
  - unsorted is sticky until the first in handshake of the next batch or rst.
- Undefined: no prev register; unsorted is tied to 0. The port remains present.

Test Plan:
- Load 5,3,7,1,0,6,2,4 with out_ready=1 and an engine instance attached -> out stream 0,1,2,3,4,5,6,7; done pulses once with the word 7; err=0; unsorted=0.
- Check pin activity on the same run -> exactly 8 srt_wr pulses at addr 0..7, then exactly 1 srt_start pulse, then srt_addr 0..7 in RD. srt_wr and srt_start never overlap.
- Hold out_ready=0 for 5 cycles on word 2 -> out_data stays at 2 and out_valid stays 1 for the whole stall; srt_addr unchanged; no word is lost or duplicated.
- Engine stub keeps srt_ready=1 forever -> after 1023 cycles in WAIT_LO, err=1 and in_ready=0; with rst high for 1 cycle -> err=0, in_ready=1.
- Assert rst in OUT after 3 of 8 words -> next cycle out_valid=0, in_ready=1, cnt=0. A fresh batch of eight copies of 9 then yields eight 9s.
- With SORT_HOST_CHECK_EN and an engine stub returning 4,2,... -> unsorted=1 on the second output handshake. The next batch's first input clears it.
